axi4_write_burst_manager: RTL

- Manager-side write engine that converts a simple command and data-beat stream into one AXI4 INCR write burst.
- Drives the AW, W and B channels of the team's AXI4 bus as the Manager.
- Returns the write response on a ready/valid response port.
- One transaction outstanding at a time; the upstream cache/DMA side sits on the command/data ports.

---
 rtl/axi4_write_burst_manager.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/axi4_write_burst_manager.sv
`default_nettype none
// ============================================================================
// Module      : axi4_write_burst_manager
// Description : Manager-side AXI4 write engine. Accepts one command
//               (address, beats-1, id), issues a single INCR burst on AW,
//               streams the upstream data beats onto W, collects the B
//               response and returns it on a ready/valid response port.
//               One transaction is outstanding at a time.
// Ports       : aclk/aresetn          clock, synchronous active-low reset
//               cmd_*                 command handshake and payload
//               data_*                write beat handshake, data, strobes
//               resp_*                response handshake, error flag, id
//               aw*/w*/b*             AXI4 write address/data/response
// Revision    : 1.0 - initial release
// ============================================================================
module axi4_write_burst_manager #(
    parameter int AXI_ADDR_WIDTH = 64,
    parameter int AXI_DATA_WIDTH = 64,   // 8..1024, power of 2
    parameter int AXI_ID_WIDTH   = 1
) (
    input  logic                          aclk,
    input  logic                          aresetn,
    // Command port
    input  logic                          cmd_v_i,
    output logic                          cmd_ready_o,
    input  logic [AXI_ADDR_WIDTH-1:0]     cmd_addr_i,
    input  logic [7:0]                    cmd_len_i,
    input  logic [AXI_ID_WIDTH-1:0]       cmd_id_i,
    // Write beat port
    input  logic                          data_v_i,
    output logic                          data_ready_o,
    input  logic [AXI_DATA_WIDTH-1:0]     data_i,
    input  logic [AXI_DATA_WIDTH/8-1:0]   data_mask_i,
    // Response port
    output logic                          resp_v_o,
    input  logic                          resp_ready_i,
    output logic                          resp_err_o,
    output logic [AXI_ID_WIDTH-1:0]       resp_id_o,
    // AXI4 AW channel
    output logic [AXI_ADDR_WIDTH-1:0]     awaddr,
    output logic [AXI_ID_WIDTH-1:0]       awid,
    output logic [7:0]                    awlen,
    output logic [2:0]                    awsize,
    output logic [1:0]                    awburst,
    output logic                          awlock,
    output logic [3:0]                    awcache,
    output logic [2:0]                    awprot,
    output logic [3:0]                    awqos,
    output logic [3:0]                    awregion,
    output logic                          awvalid,
    input  logic                          awready,
    // AXI4 W channel
    output logic [AXI_DATA_WIDTH-1:0]     wdata,
    output logic [AXI_DATA_WIDTH/8-1:0]   wstrb,
    output logic                          wlast,
    output logic                          wvalid,
    input  logic                          wready,
    // AXI4 B channel
    input  logic                          bvalid,
    output logic                          bready,
    input  logic [AXI_ID_WIDTH-1:0]       bid,
    input  logic [1:0]                    bresp
);

    localparam logic [2:0] c_AWSIZE = 3'($clog2(AXI_DATA_WIDTH / 8));

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_AW   = 3'd1,
        S_W    = 3'd2,
        S_B    = 3'd3,
        S_RESP = 3'd4
    } state_t;

    state_t                      r_state;
    state_t                      w_next;
    logic [AXI_ADDR_WIDTH-1:0]   r_addr;
    logic [7:0]                  r_len;
    logic [AXI_ID_WIDTH-1:0]     r_id;
    logic [7:0]                  r_cnt;
    logic [1:0]                  r_bresp;
    logic [AXI_ID_WIDTH-1:0]     r_bid;

    logic w_cmd_hs;
    logic w_beat_hs;
    logic w_b_hs;

    // Handshakes use the gated outputs, so nothing is accepted during reset.
    assign w_cmd_hs  = cmd_v_i & cmd_ready_o;
    assign w_beat_hs = wvalid & wready;
    assign w_b_hs    = bvalid & bready;

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_state <= S_IDLE;
            r_addr  <= '0;
            r_len   <= '0;
            r_id    <= '0;
            r_cnt   <= '0;
            r_bresp <= '0;
            r_bid   <= '0;
        end else begin
            r_state <= w_next;
            if (w_cmd_hs) begin
                r_addr <= cmd_addr_i;
                r_len  <= cmd_len_i;
                r_id   <= cmd_id_i;
                r_cnt  <= '0;
            end
            // Wraps only after the final beat of a 256-beat burst.
            if (w_beat_hs) begin
                r_cnt <= r_cnt + 8'd1;
            end
            if (w_b_hs) begin
                r_bresp <= bresp;
                r_bid   <= bid;
            end
        end
    end

    always_comb begin
        w_next       = r_state;
        cmd_ready_o  = 1'b0;
        awvalid      = 1'b0;
        wvalid       = 1'b0;
        data_ready_o = 1'b0;
        bready       = 1'b0;
        resp_v_o     = 1'b0;
        case (r_state)
            S_IDLE: begin
                cmd_ready_o = 1'b1;
                if (cmd_v_i) w_next = S_AW;
            end
            S_AW: begin
                awvalid = 1'b1;
                if (awready) w_next = S_W;
            end
            S_W: begin
                wvalid       = data_v_i;
                data_ready_o = wready;
                if (data_v_i && wready && wlast) w_next = S_B;
            end
            S_B: begin
                bready = 1'b1;
                if (bvalid) w_next = S_RESP;
            end
            S_RESP: begin
                resp_v_o = 1'b1;
                if (resp_ready_i) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
        // Handshake outputs are forced low for as long as reset is held.
        if (!aresetn) begin
            cmd_ready_o  = 1'b0;
            awvalid      = 1'b0;
            wvalid       = 1'b0;
            data_ready_o = 1'b0;
            bready       = 1'b0;
            resp_v_o     = 1'b0;
        end
    end

    assign wlast      = (r_cnt == r_len);
    assign wdata      = data_i;
    assign wstrb      = data_mask_i;

    assign awaddr     = r_addr;
    assign awid       = r_id;
    assign awlen      = r_len;
    assign awsize     = c_AWSIZE;
    assign awburst    = 2'b01;
    assign awlock     = 1'b0;
    assign awcache    = 4'b0011;
    assign awprot     = 3'b000;
    assign awqos      = 4'b0000;
    assign awregion   = 4'b0000;

    assign resp_err_o = (r_bresp != 2'b00);
    assign resp_id_o  = r_bid;

endmodule
`default_nettype wire
